// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode, flag and helper definitions shared by the ALU pipeline
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_NOT   = 4'd5,
        OP_SHL   = 4'd6,
        OP_SHR   = 4'd7,
        OP_ROL   = 4'd8,
        OP_ROR   = 4'd9,
        OP_INC   = 4'd10,
        OP_DEC   = 4'd11,
        OP_PASSB = 4'd12
    } op_e;

    localparam logic [3:0] OP_LAST_LEGAL = 4'd12;

    typedef struct packed {
        logic co;
        logic zero;
        logic ovf;
        logic err;
    } flags_t;

    // Opcodes above OP_LAST_LEGAL report err and never touch the accumulator.
    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_LAST_LEGAL;
    endfunction

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational WIDTH-bit ALU datapath producing result and flags
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] y,
    output flags_t           flags
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    logic [SHW-1:0]   sh;
    logic [SHW:0]     sh_rev;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   inc;
    logic [WIDTH:0]   dec;

    assign sh     = b[SHW-1:0];
    // Complementary amount for the wrap-around half of a rotate; a shift by WIDTH yields 0.
    assign sh_rev = (SHW+1)'(WIDTH) - {1'b0, sh};

    // Extended-width arithmetic so bit WIDTH carries the carry/borrow.
    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};
        inc  = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
        dec  = {1'b0, a} - {{WIDTH{1'b0}}, 1'b1};
    end

    // Opcode decode: select result, then derive flags; zero always follows y.
    always_comb begin
        y     = '0;
        flags = '0;
        case (op)
            OP_ADD: begin
                y         = sum[WIDTH-1:0];
                flags.co  = sum[WIDTH];
                flags.ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                y         = diff[WIDTH-1:0];
                flags.co  = diff[WIDTH];
                flags.ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_NOT:   y = ~a;
            OP_SHL:   y = a << sh;
            OP_SHR:   y = a >> sh;
            OP_ROL:   y = (a << sh) | (a >> sh_rev);
            OP_ROR:   y = (a >> sh) | (a << sh_rev);
            OP_INC: begin
                y         = inc[WIDTH-1:0];
                flags.co  = inc[WIDTH];
                flags.ovf = !a[MSB] && inc[MSB];
            end
            OP_DEC: begin
                y         = dec[WIDTH-1:0];
                flags.co  = dec[WIDTH];
                flags.ovf = a[MSB] && !dec[MSB];
            end
            OP_PASSB: y = b;
            default:  flags.err = 1'b1;
        endcase
        flags.zero = (y == '0);
    end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage valid/ready ALU pipeline with result accumulator
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [3:0]       op_in,
    input  logic             acc_sel_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y_out,
    output logic             co_out,
    output logic             zero_out,
    output logic             ovf_out,
    output logic             err_out
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [3:0]       s1_op;
    logic             s1_acc_sel;

    logic [WIDTH-1:0] acc;
    flags_t           flags_q;

    logic [WIDTH-1:0] core_a;
    logic [WIDTH-1:0] core_y;
    flags_t           core_flags;

    logic             advance_s1;
    logic             advance_s2;
    logic             in_fire;

    // The output register frees when empty or drained; S1 frees when empty or moving on.
    assign advance_s2 = !out_valid || out_ready;
    assign advance_s1 = !s1_valid || advance_s2;
    assign in_ready   = advance_s1 && !reset;
    assign in_fire    = in_valid && in_ready;

    // The accumulator is read here, as the op leaves S1, so it already holds the
    // result of the op just ahead and back-to-back chains need no bubble.
    assign core_a = s1_acc_sel ? acc : s1_a;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a     (core_a),
        .b     (s1_b),
        .op    (s1_op),
        .y     (core_y),
        .flags (core_flags)
    );

    // S1 capture: hold operands until the output stage can take them.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_op      <= '0;
            s1_acc_sel <= 1'b0;
        end else if (advance_s1) begin
            s1_valid <= in_fire;
            if (in_fire) begin
                s1_a       <= a_in;
                s1_b       <= b_in;
                s1_op      <= op_in;
                s1_acc_sel <= acc_sel_in;
            end
        end
    end

    // Output stage and accumulator: load together; outputs hold while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            y_out     <= '0;
            flags_q   <= '0;
            acc       <= '0;
        end else if (advance_s2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                y_out   <= core_y;
                flags_q <= core_flags;
                if (op_legal(s1_op)) begin
                    acc <= core_y;
                end
            end
        end
    end

    assign co_out   = flags_q.co;
    assign zero_out = flags_q.zero;
    assign ovf_out  = flags_q.ovf;
    assign err_out  = flags_q.err;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed and random checks of alu_pipe against an arithmetic reference model
module tb_alu_pipe;

    typedef struct packed {
        logic [7:0] y;
        logic       co;
        logic       zero;
        logic       ovf;
        logic       err;
    } res_t;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic [3:0] op_in;
    logic       acc_sel_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y_out;
    logic       co_out;
    logic       zero_out;
    logic       ovf_out;
    logic       err_out;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   macc   = 0;
    res_t exp_q[$];
    logic last_in_ready;

    alu_pipe #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_in       (a_in),
        .b_in       (b_in),
        .op_in      (op_in),
        .acc_sel_in (acc_sel_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y_out      (y_out),
        .co_out     (co_out),
        .zero_out   (zero_out),
        .ovf_out    (ovf_out),
        .err_out    (err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int to_signed8(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    function automatic res_t ref_op(input int a, input int b, input int op);
        res_t r;
        int   sa, sb, s, n, yv;
        r  = '0;
        yv = 0;
        sa = to_signed8(a);
        sb = to_signed8(b);
        n  = b % 8;
        case (op)
            0:  begin s = a + b; yv = s & 255; r.co = (s > 255); r.ovf = (sa + sb > 127) || (sa + sb < -128); end
            1:  begin s = a - b; yv = s & 255; r.co = (a < b);   r.ovf = (sa - sb > 127) || (sa - sb < -128); end
            2:  yv = a & b;
            3:  yv = a | b;
            4:  yv = a ^ b;
            5:  yv = (~a) & 255;
            6:  yv = (a << n) & 255;
            7:  yv = a >> n;
            8:  yv = ((a << n) | (a >> (8 - n))) & 255;
            9:  yv = ((a >> n) | (a << (8 - n))) & 255;
            10: begin s = a + 1; yv = s & 255; r.co = (s > 255); r.ovf = (sa + 1 > 127); end
            11: begin s = a - 1; yv = s & 255; r.co = (a == 0);  r.ovf = (sa - 1 < -128); end
            12: yv = b;
            default: r.err = 1'b1;
        endcase
        r.y    = yv[7:0];
        r.zero = (r.y == 8'd0);
        return r;
    endfunction

    task automatic model_push(input int a, input int b, input int op, input bit acc_sel);
        res_t r;
        r = ref_op(acc_sel ? macc : a, b, op);
        exp_q.push_back(r);
        if (op <= 12) macc = int'(r.y);
    endtask

    task automatic set_in(input bit v, input int a, input int b, input int op, input bit s, input bit ordy);
        in_valid   = v;
        a_in       = a[7:0];
        b_in       = b[7:0];
        op_in      = op[3:0];
        acc_sel_in = s;
        out_ready  = ordy;
    endtask

    // One clock: sample mid-high-phase, score the output, log the handshake, advance.
    task automatic tick(output bit hs);
        res_t obs;
        #2;
        last_in_ready = in_ready;
        check("in_ready", in_ready, (exp_q.size() < 2) || out_ready);
        if (out_valid) begin
            check("spurious_out", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                obs = {y_out, co_out, zero_out, ovf_out, err_out};
                check("result", obs, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
        hs = in_valid && in_ready;
        if (hs) model_push(int'(a_in), int'(b_in), int'(op_in), acc_sel_in);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycle();
        reset = 1'b1;
        #2;
        check("reset_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_outputs", {y_out, co_out, zero_out, ovf_out, err_out}, 0);
        exp_q.delete();
        macc = 0;
    endtask

    task automatic drain();
        bit hs;
        set_in(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick(hs);
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        bit hs;
        int sent;
        int stall_seen;
        int stall_left;
        int bp_op[4];
        int bp_a[4];
        int bp_b[4];

        set_in(0, 0, 0, 0, 0, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset_cycle();
        reset_cycle();
        reset = 1'b0;

        // Latency: ADD 0xFF + 0x01, out_valid appears two cycles after the handshake cycle.
        set_in(1, 8'hFF, 8'h01, 0, 0, 1);
        tick(hs);
        check("lat_handshake", hs, 1);
        set_in(0, 0, 0, 0, 0, 1);
        check("lat_cycle1", out_valid, 0);
        tick(hs);
        check("lat_cycle2", out_valid, 1);
        check("add_carry_zero", {y_out, co_out, zero_out, ovf_out, err_out}, {8'h00, 4'b1100});
        tick(hs);

        // SUB overflow and borrow cases, back to back.
        set_in(1, 8'h80, 8'h01, 1, 0, 1); tick(hs);
        set_in(1, 8'h03, 8'h05, 1, 0, 1); tick(hs);
        drain();

        // Accumulator chain: ADD 5+3, INC acc, SHL acc by 2.
        set_in(1, 5, 3, 0, 0, 1);    tick(hs);
        set_in(1, 8'hAA, 0, 10, 1, 1); tick(hs);
        set_in(1, 8'h55, 2, 6, 1, 1);  tick(hs);
        drain();

        // Backpressure: four ops, consumer stalls 3 cycles once the first result appears.
        bp_op = '{0, 4, 9, 12};
        bp_a  = '{8'h10, 8'hF0, 8'h81, 8'h00};
        bp_b  = '{8'h22, 8'h0F, 8'h03, 8'h7E};
        sent = 0;
        stall_seen = 0;
        stall_left = 3;
        for (int c = 0; c < 30 && (sent < 4 || exp_q.size() > 0); c++) begin
            bit ordy;
            ordy = 1'b1;
            if (out_valid && stall_left > 0) begin
                ordy = 1'b0;
                stall_left--;
            end
            if (sent < 4) set_in(1, bp_a[sent], bp_b[sent], bp_op[sent], 0, ordy);
            else          set_in(0, 0, 0, 0, 0, ordy);
            tick(hs);
            if (!last_in_ready) stall_seen++;
            if (hs) sent++;
        end
        check("bp_sent", sent, 4);
        check("bp_stalled", stall_seen > 0, 1);
        drain();

        // Illegal opcode leaves the accumulator alone for the following INC.
        set_in(1, 8'h40, 8'h07, 12, 0, 1); tick(hs);
        set_in(1, 8'h12, 8'h00, 14, 0, 1); tick(hs);
        set_in(1, 8'h99, 8'h00, 10, 1, 1); tick(hs);
        drain();

        // Random traffic with random backpressure and accumulator use.
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 3) != 0, $urandom_range(0, 255), $urandom_range(0, 255),
                   $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 3) != 0);
            tick(hs);
        end
        drain();

        // Reset with two transactions in flight discards them and clears the accumulator.
        set_in(1, 8'h21, 8'h01, 0, 0, 0); tick(hs);
        set_in(1, 8'h31, 8'h02, 3, 0, 0); tick(hs);
        check("flight_out_valid", out_valid, 1);
        in_valid = 1'b1;
        reset_cycle();
        reset_cycle();
        reset = 1'b0;
        set_in(1, 8'h55, 8'h00, 10, 1, 1); tick(hs);
        set_in(0, 0, 0, 0, 0, 1);
        tick(hs);
        check("post_reset_inc", {out_valid, y_out}, {1'b1, 8'h01});
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
